key_led_counter: RTL and testbench



---
 rtl/key_led_pkg.sv | 23 ++
 rtl/key_filter.sv | 96 +++++++++
 rtl/key_led_counter.sv | 70 +++++++
 tb/tb_key_led_counter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared definitions for the two-key LED counter.
//   key_fsm_e         : debounce FSM states
//   DefaultClkFreqHz  : board clock (50 MHz core board)
//   DefaultDebounceMs : key stability window in milliseconds
//   debounce_cycles() : stability window expressed in clock cycles
package key_led_pkg;

  typedef enum logic [1:0] {
    StIdle,       // key released
    StPressFilt,  // key seen low, waiting for it to stay low
    StDown,       // press accepted, key held
    StRelFilt     // key seen high, waiting for it to stay high
  } key_fsm_e;

  localparam int unsigned DefaultClkFreqHz  = 50_000_000;
  localparam int unsigned DefaultDebounceMs = 20;

  function automatic int unsigned debounce_cycles(input int unsigned clk_freq_hz,
                                                  input int unsigned debounce_ms);
    return clk_freq_hz / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/key_filter.sv
// Synchroniser plus debounce filter for one active-low mechanical key.
//   Clk       in  system clock, rising edge
//   Rst_n     in  asynchronous active-low reset
//   key_in    in  raw key level, active-low, asynchronous to Clk
//   key_flag  out single-cycle pulse when a press is accepted
//   key_state out 1 while released or filtering a press, 0 while held or filtering a release
module key_filter
  import key_led_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DefaultClkFreqHz,
  parameter int unsigned DEBOUNCE_MS = DefaultDebounceMs
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

  localparam int unsigned DebounceCycles = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned TimerW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(DebounceCycles - 1);

  logic [1:0]        sync_q;
  logic              key_sync;
  key_fsm_e          state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              flag_q, flag_d;

  // Synchroniser resets to the idle (released) level so reset never looks like a press.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign key_sync = sync_q[1];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flag_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!key_sync) begin
          state_d = StPressFilt;
          timer_d = '0;
        end
      end
      StPressFilt: begin
        if (key_sync) begin
          state_d = StIdle;
        end else if (timer_q == TimerMax) begin
          state_d = StDown;
          flag_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDown: begin
        if (key_sync) begin
          state_d = StRelFilt;
          timer_d = '0;
        end
      end
      StRelFilt: begin
        if (!key_sync) begin
          state_d = StDown;
        end else if (timer_q == TimerMax) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flag_q  <= flag_d;
    end
  end

  assign key_flag  = flag_q;
  assign key_state = (state_q == StIdle) || (state_q == StPressFilt);

endmodule

// File: rtl/key_led_counter.sv
// Board top level: two debounced keys step a 2-bit up/down counter shown on two LEDs.
//   Clk      in  system clock, rising edge
//   Rst_n    in  asynchronous active-low reset
//   key_in0  in  raw key 0 (increment), active-low
//   key_in1  in  raw key 1 (decrement), active-low
//   led      out counter value, active-high
module key_led_counter
  import key_led_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DefaultClkFreqHz,
  parameter int unsigned DEBOUNCE_MS = DefaultDebounceMs
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       key_in0,
  input  logic       key_in1,
  output logic [1:0] led
);

  logic       flag0, flag1;
  logic       key_state0, key_state1;
  logic [1:0] count_q, count_d;
  logic       unused_key_state;

  key_filter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_key_filter0 (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .key_in   (key_in0),
    .key_flag (flag0),
    .key_state(key_state0)
  );

  key_filter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_key_filter1 (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .key_in   (key_in1),
    .key_flag (flag1),
    .key_state(key_state1)
  );

  // Held-key level is not needed by the counter.
  assign unused_key_state = key_state0 ^ key_state1;

  // Simultaneous up and down presses cancel.
  always_comb begin
    count_d = count_q;
    case ({flag1, flag0})
      2'b01:   count_d = count_q + 2'd1;
      2'b10:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= 2'b00;
    end else begin
      count_q <= count_d;
    end
  end

  assign led = count_q;

endmodule

// File: tb/tb_key_led_counter.sv
module tb_key_led_counter;

  // Scaled clock so one debounce window is 200 cycles; 10 cycles per "ms".
  localparam int unsigned ClkFreqHz  = 10_000;
  localparam int unsigned DebounceMs = 20;
  localparam int          Cpm        = ClkFreqHz / 1000;
  localparam int          Dc         = Cpm * DebounceMs;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       key_in0 = 1'b1;
  logic       key_in1 = 1'b1;
  logic [1:0] led;

  always #5 clk = ~clk;

  key_led_counter #(
    .CLK_FREQ_HZ(ClkFreqHz),
    .DEBOUNCE_MS(DebounceMs)
  ) dut (
    .Clk    (clk),
    .Rst_n  (rst_n),
    .key_in0(key_in0),
    .key_in1(key_in1),
    .led    (led)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] led;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks    = 0;
  int         errors    = 0;
  logic [1:0] led_prev  = 2'b00;
  int         flag0_cnt = 0;
  int         flag1_cnt = 0;
  int         flag_skew = 0;

  // One clock: sample on the falling edge, count flags, retire scoreboard entries.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (dut.u_key_filter0.key_flag === 1'b1) flag0_cnt++;
    if (dut.u_key_filter1.key_flag === 1'b1) flag1_cnt++;
    if (dut.u_key_filter0.key_flag !== dut.u_key_filter1.key_flag) flag_skew++;
    if (led !== led_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_led_change cyc=%0d led=%b prev=%b required no change",
                 cyc, led, led_prev);
      end else begin
        e = sb.pop_front();
        if (led !== e.led || cyc != e.cyc) begin
          errors++;
          $display("FAIL led_step got led=%b at cyc=%0d required led=%b at cyc=%0d",
                   led, cyc, e.led, e.cyc);
        end
      end
      led_prev = led;
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL led_step_missing led=%b at cyc=%0d required led=%b at cyc=%0d",
               led, cyc, e.led, e.cyc);
    end
  endtask

  task automatic drive(input bit use0, input bit use1, input logic v);
    if (use0) key_in0 = v;
    if (use1) key_in1 = v;
  endtask

  // Behavioural key: bouncy press, ~50 ms hold, bouncy release, 80 ms gap.
  task automatic press(input bit use0, input bit use1, input bit step, input logic [1:0] exp_led);
    int bt;
    int t;
    int seg;
    bt = int'($urandom_range(5 * Cpm, Cpm));
    t  = 0;
    while (t < bt) begin
      drive(use0, use1, 1'b0);
      seg = int'($urandom_range(6, 1));
      repeat (seg) tick();
      t += seg;
      drive(use0, use1, 1'b1);
      seg = int'($urandom_range(6, 1));
      repeat (seg) tick();
      t += seg;
    end
    drive(use0, use1, 1'b0);
    // Next rising edge latches into the synchroniser; led moves Dc+3 edges after that.
    if (step) sb.push_back('{led: exp_led, cyc: cyc + Dc + 4});
    repeat (50 * Cpm) tick();
    bt = int'($urandom_range(5 * Cpm, Cpm));
    t  = 0;
    while (t < bt) begin
      drive(use0, use1, 1'b1);
      seg = int'($urandom_range(6, 1));
      repeat (seg) tick();
      t += seg;
      drive(use0, use1, 1'b0);
      seg = int'($urandom_range(6, 1));
      repeat (seg) tick();
      t += seg;
    end
    drive(use0, use1, 1'b1);
    repeat (80 * Cpm) tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_in0 = 1'b1;
    key_in1 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("FAIL reset_led got %b required 00", led);
    end
    rst_n     = 1'b1;
    led_prev  = 2'b00;
    flag0_cnt = 0;
    flag1_cnt = 0;
    repeat (10) tick();
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("FAIL idle_led got %b required 00", led);
    end
    checks++;
    if (flag0_cnt + flag1_cnt != 0) begin
      errors++;
      $display("FAIL idle_flags got %0d required 0", flag0_cnt + flag1_cnt);
    end
  endtask

  task automatic test_increment();
    logic [1:0] exp_led;
    for (int i = 0; i < 2; i++) begin
      exp_led   = 2'(i + 1);
      flag0_cnt = 0;
      flag1_cnt = 0;
      press(1'b1, 1'b0, 1'b1, exp_led);
      checks++;
      if (flag0_cnt != 1 || flag1_cnt != 0) begin
        errors++;
        $display("FAIL inc_flags press=%0d got f0=%0d f1=%0d required f0=1 f1=0",
                 i, flag0_cnt, flag1_cnt);
      end
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL inc_led press=%0d got %b required %b", i, led, exp_led);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL inc_pending got %0d required 0", sb.size());
    end
  endtask

  task automatic test_decrement();
    logic [1:0] exp_led;
    for (int i = 0; i < 2; i++) begin
      exp_led   = 2'(1 - i);
      flag0_cnt = 0;
      flag1_cnt = 0;
      press(1'b0, 1'b1, 1'b1, exp_led);
      checks++;
      if (flag1_cnt != 1 || flag0_cnt != 0) begin
        errors++;
        $display("FAIL dec_flags press=%0d got f0=%0d f1=%0d required f0=0 f1=1",
                 i, flag0_cnt, flag1_cnt);
      end
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL dec_led press=%0d got %b required %b", i, led, exp_led);
      end
    end
  endtask

  task automatic test_wrap();
    press(1'b0, 1'b1, 1'b1, 2'b11);
    checks++;
    if (led !== 2'b11) begin
      errors++;
      $display("FAIL wrap_down got %b required 11", led);
    end
    press(1'b1, 1'b0, 1'b1, 2'b00);
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("FAIL wrap_up got %b required 00", led);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_pending got %0d required 0", sb.size());
    end
  endtask

  task automatic test_glitch();
    flag0_cnt = 0;
    key_in0   = 1'b0;
    repeat (Dc / 2) tick();
    key_in0 = 1'b1;
    repeat (2 * Dc) tick();
    checks++;
    if (flag0_cnt != 0) begin
      errors++;
      $display("FAIL glitch_flag got %0d required 0", flag0_cnt);
    end
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("FAIL glitch_led got %b required 00", led);
    end
  endtask

  task automatic test_both();
    press(1'b1, 1'b0, 1'b1, 2'b01);
    flag0_cnt = 0;
    flag1_cnt = 0;
    flag_skew = 0;
    press(1'b1, 1'b1, 1'b0, 2'b01);
    checks++;
    if (flag0_cnt != 1 || flag1_cnt != 1) begin
      errors++;
      $display("FAIL both_flags got f0=%0d f1=%0d required f0=1 f1=1", flag0_cnt, flag1_cnt);
    end
    checks++;
    if (flag_skew != 0) begin
      errors++;
      $display("FAIL both_coincide got skew=%0d required 0", flag_skew);
    end
    checks++;
    if (led !== 2'b01) begin
      errors++;
      $display("FAIL both_led got %b required 01", led);
    end
  endtask

  task automatic test_reset_mid_filter();
    flag0_cnt = 0;
    key_in0   = 1'b0;
    repeat (Dc / 2) tick();
    // Asynchronous reset clears led immediately; seen at the next sample.
    sb.push_back('{led: 2'b00, cyc: cyc + 1});
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    // Too short for a fresh filter, long enough for an un-aborted one to fire.
    repeat (Dc - 20) tick();
    key_in0 = 1'b1;
    repeat (2 * Dc) tick();
    checks++;
    if (flag0_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_flag got %0d required 0", flag0_cnt);
    end
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_led got %b required 00", led);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_pending got %0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_decrement();
    test_wrap();
    test_glitch();
    test_both();
    test_reset_mid_filter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
